// File: rtl/mul_pkg.sv
// Shared constants, state encoding and sizing helper for the iterative multiplier.
// Holds operand/limb widths, limb count, counter width and FSM state type.
package mul_pkg;

    function automatic int nb_limbs(input int logq, input int bw);
        return (logq + bw - 1) / bw;
    endfunction

    localparam int LOGQ  = 60;
    localparam int LOGQH = 17;
    localparam int BW    = 15;
    localparam int LOGC  = 2 * LOGQ;
    localparam int NB    = nb_limbs(LOGQ, BW);
    localparam int CNTW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int BPW   = NB * BW;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mul_limb.sv
// One limb step: LOGQ x BW multiply, shifted into place and added to the accumulator.
// Ports: a (multiplicand), limb (B slice), cnt (limb index), acc (current sum), acc_next (updated sum).
module mul_limb
    import mul_pkg::*;
(
    input  logic [LOGQ-1:0] a,
    input  logic [BW-1:0]   limb,
    input  logic [CNTW-1:0] cnt,
    input  logic [LOGC-1:0] acc,
    output logic [LOGC-1:0] acc_next
);

    logic [LOGQ+BW-1:0] pp;
    logic [LOGC-1:0]    pp_ext;

    assign pp     = {{BW{1'b0}}, a} * {{LOGQ{1'b0}}, limb};
    assign pp_ext = {{(LOGC-LOGQ-BW){1'b0}}, pp};

    // Bits shifted past LOGC are always zero since A, B < 2^LOGQ.
    assign acc_next = acc + (pp_ext << (32'(cnt) * BW));

endmodule

// File: rtl/mul_iter.sv
// Iterative limb-serial multiplier: C = A*B, one BW-bit limb of B per cycle; qH rides along.
// Ports: clk, rst (async high), in_valid/in_ready, A, B, qH_in -> out_valid pulse, C, qH.
// Option: MUL_ITER_EARLY_EXIT_EN stops after the highest non-zero B limb (B=0 skips RUN).
module mul_iter
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQ-1:0]  A,
    input  logic [LOGQ-1:0]  B,
    input  logic [LOGQH-1:0] qH_in,
    output logic             out_valid,
    output logic [LOGC-1:0]  C,
    output logic [LOGQH-1:0] qH
);

    state_t state, state_n;

    logic [LOGQ-1:0]  a_reg;
    logic [BPW-1:0]   b_reg;
    logic [BPW-1:0]   b_pad;
    logic [LOGQH-1:0] qh_reg;
    logic [LOGC-1:0]  acc;
    logic [LOGC-1:0]  acc_next;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  last;
    logic [BW-1:0]    limb;
    logic             load;
    logic             step;
    logic             fire;
    logic             b_zero;

    assign b_pad = (BPW)'(B);
    assign limb  = BW'(b_reg >> (32'(cnt) * BW));

    mul_limb u_limb (
        .a        (a_reg),
        .limb     (limb),
        .cnt      (cnt),
        .acc      (acc),
        .acc_next (acc_next)
    );

`ifdef MUL_ITER_EARLY_EXIT_EN
    logic [CNTW-1:0] nz;

    always_comb begin
        nz = '0;
        for (int i = 0; i < NB; i++) begin
            if (b_pad[i*BW +: BW] != '0) nz = CNTW'(i);
        end
    end

    assign b_zero = (B == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= '0;
        else if (load) last <= nz;
    end
`else
    assign b_zero = 1'b0;
    assign last   = CNTW'(NB - 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        fire     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = b_zero ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == last) state_n = DONE;
            end
            DONE: begin
                in_ready = 1'b1;
                fire     = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = b_zero ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            qh_reg    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            C         <= '0;
            qH        <= '0;
        end else begin
            out_valid <= fire;
            if (fire) begin
                C  <= acc;
                qH <= qh_reg;
            end
            if (load) begin
                a_reg  <= A;
                b_reg  <= b_pad;
                qh_reg <= qH_in;
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed corner cases plus random operand stream.
// Reference model: plain wide multiply, limb-count latency and a queue of pending results.
module tb_mul_iter;
    import mul_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LOGQ-1:0]  A;
    logic [LOGQ-1:0]  B;
    logic [LOGQH-1:0] qH_in;
    logic             out_valid;
    logic [LOGC-1:0]  C;
    logic [LOGQH-1:0] qH;

    mul_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .qH_in     (qH_in),
        .out_valid (out_valid),
        .C         (C),
        .qH        (qH)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LOGC-1:0]  c;
        logic [LOGQH-1:0] q;
        int               due;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_until = -1;
    bit   rdy_m = 1'b1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Index of highest limb the multiplier must process for this B.
    function automatic int nz_of(input logic [LOGQ-1:0] b);
`ifdef MUL_ITER_EARLY_EXIT_EN
        int n;
        logic [LOGQ-1:0] s;
        n = -1;
        for (int i = 0; i < NB; i++) begin
            s = b >> (i * BW);
            if (s[BW-1:0] != '0) n = i;
        end
        return n;
`else
        return NB - 1;
`endif
    endfunction

    always @(posedge clk) begin
        int nz;
        logic [LOGC-1:0] p;
        cyc++;
        if (!rst && in_valid && rdy_m) begin
            nz = nz_of(B);
            p = {{LOGQ{1'b0}}, A} * {{LOGQ{1'b0}}, B};
            q_exp.push_back('{c: p, q: qH_in, due: cyc + nz + 2});
            busy_until = cyc + nz;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rdy_m = 1'b1;
        end else begin
            rdy_m = (cyc > busy_until);
            check("in_ready", in_ready, rdy_m);
            if (out_valid) begin
                if (q_exp.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    e = q_exp.pop_front();
                    check("C", C, e.c);
                    check("qH", qH, e.q);
                    check("latency", cyc, e.due);
                end
            end else if (q_exp.size() != 0 && cyc >= q_exp[0].due) begin
                check("valid_at_due", out_valid, 1);
                void'(q_exp.pop_front());
            end
        end
    end

    task automatic send(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                        input logic [LOGQH-1:0] q);
        A = a;
        B = b;
        qH_in = q;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (rdy_m) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", in_ready, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (q_exp.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain", q_exp.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ta;
        logic [63:0] tb;
        int mode;
        int gap;
        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        qH_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_C", C, 0);
        check("rst_qH", qH, 0);
        @(negedge clk);
        rst = 1'b0;

        send(60'hFFFFFFFFFFFFFFF, 60'hFFFFFFFFFFFFFFF, 17'h1ABCD);
        drain();
        check("max_C", C, 120'hFFFFFFFFFFFFFFE000000000000001);
        check("max_qH", qH, 17'h1ABCD);

        send(60'd3, 60'd5, 17'h00001);
        send(60'h123456789, 60'h10, 17'h00002);
        drain();
        check("b2b_C", C, 120'h1234567890);

        send(60'h55, 60'h66, 17'h00004);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_exp.delete();
        busy_until = -1;
        #1;
        check("abort_C", C, 120'h1234567890 & 120'h0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        send(60'd7, 60'd9, 17'h00005);
        drain();
        check("after_abort_C", C, 120'h3F);

        send(60'h0ABCDEF, 60'd0, 17'h00003);
        drain();
        check("zero_C", C, 0);
        check("zero_qH", qH, 17'h00003);

        for (int n = 0; n < 300; n++) begin
            ta = {$urandom(), $urandom()};
            tb = {$urandom(), $urandom()};
            mode = $urandom_range(0, 4);
            case (mode)
                0: tb = 64'd0;
                1: tb = tb & 64'h7FFF;
                2: tb = tb & 64'h3FFFFFFF;
                3: ta = 64'd0;
                default: ;
            endcase
            send(ta[LOGQ-1:0], tb[LOGQ-1:0], LOGQH'($urandom()));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
